// File: rtl/mem_1r1w_masked_client_pkg.sv
// rtl/mem_1r1w_masked_client_pkg.sv - shared sizes and types for the 1R1W masked SRAM client
package mem_client_pkg;

  localparam int DEPTH     = 48;
  localparam int WIDTH     = 64;
  localparam int MASK_GRAN = 8;
  localparam int ADDR_W    = 6;
  localparam int MASK_W    = WIDTH / MASK_GRAN;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } resp_t;

endpackage

// File: rtl/mem_1r1w_masked_client_if.sv
// rtl/mem_1r1w_masked_client_if.sv - request/response streams between a pipeline client and the SRAM client
interface mem_1r1w_masked_client_if;
  import mem_client_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_data;
  logic [MASK_W-1:0] req_mask;
  logic              resp_valid;
  logic              resp_ready;
  logic [WIDTH-1:0]  resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_data, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_mask, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/mem_1r1w_masked_client_resp_fifo2.sv
// rtl/mem_1r1w_masked_client_resp_fifo2.sv - two-entry in-order response FIFO
// An empty FIFO passes the incoming entry straight to the output so read data is visible the cycle it leaves the SRAM.
module resp_fifo2
  import mem_client_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       s_tvalid,
  input  resp_t      s_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output resp_t      m_tdata,
  output logic [1:0] count
);

  resp_t slot [2];
  logic  rd_ptr;
  logic  wr_ptr;
  logic  store;
  logic  drain;

  assign m_tvalid = (count != 2'd0) || s_tvalid;
  assign m_tdata  = (count != 2'd0) ? slot[rd_ptr] : s_tdata;
  assign drain    = m_tready && (count != 2'd0);
  // Bypassed entry consumed immediately never occupies a slot.
  assign store    = s_tvalid && !((count == 2'd0) && m_tready);

  always_ff @(posedge clock) begin
    if (store) begin
      slot[wr_ptr] <= s_tdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= !wr_ptr;
      end
      if (drain) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count + {1'b0, store} - {1'b0, drain};
    end
  end

endmodule

// File: rtl/mem_1r1w_masked_client.sv
// rtl/mem_1r1w_masked_client.sv - zero-fills a 1R1W byte-masked SRAM, then maps requests onto R0/W0
module mem_1r1w_masked_client
  import mem_client_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  mem_1r1w_masked_client_if.slave bus,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  output logic              R0_clk,
  input  logic [WIDTH-1:0]  R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic              W0_clk,
  output logic [WIDTH-1:0]  W0_data,
  output logic [MASK_W-1:0] W0_mask
);

  localparam logic [0:0]        ST_INIT   = 1'b0;
  localparam logic [0:0]        ST_RUN    = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] fill_cnt;
  logic              rd_inflight;
  logic              rd_err;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic              fire;
  logic              addr_ok;
  resp_t             push_data;
  resp_t             head;

  assign R0_clk = clock;
  assign W0_clk = clock;

  assign addr_ok   = bus.req_addr <= LAST_ADDR;
  // An in-flight read already owns a FIFO slot, so it counts against the two entries.
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_inflight};
  assign bus.req_ready = !reset && (state == ST_RUN) && (occupancy < 3'd2);
  assign fire      = bus.req_valid && bus.req_ready;
  assign init_done = state == ST_RUN;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_INIT;
      fill_cnt    <= '0;
      rd_inflight <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt == LAST_ADDR) begin
          state <= ST_RUN;
        end
      end
      rd_inflight <= fire && !bus.req_write;
      rd_err      <= !addr_ok;
    end
  end

  always_comb begin
    W0_en   = 1'b0;
    W0_addr = bus.req_addr;
    W0_data = bus.req_data;
    W0_mask = bus.req_mask;
    R0_en   = 1'b0;
    R0_addr = bus.req_addr;
    if (!reset) begin
      if (state == ST_INIT) begin
        W0_en   = 1'b1;
        W0_addr = fill_cnt;
        W0_data = '0;
        W0_mask = '1;
      end else if (fire) begin
        W0_en = bus.req_write && addr_ok;
        R0_en = !bus.req_write && addr_ok;
      end
    end
  end

  assign push_data.err  = rd_err;
  assign push_data.data = rd_err ? '0 : R0_data;

  resp_fifo2 u_resp_fifo (
    .clock    (clock),
    .reset    (reset),
    .s_tvalid (rd_inflight),
    .s_tdata  (push_data),
    .m_tvalid (bus.resp_valid),
    .m_tready (bus.resp_ready),
    .m_tdata  (head),
    .count    (fifo_count)
  );

  assign bus.resp_data = head.data;
  assign bus.resp_err  = head.err;

endmodule

// File: tb/tb_mem_1r1w_masked_client.sv
// tb/tb_mem_1r1w_masked_client.sv - randomized bench with a request-level memory model for the SRAM client
module tb_mem_1r1w_masked_client;
  import mem_client_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_1r1w_masked_client_if bus();

  logic              init_done;
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic              R0_clk;
  logic [WIDTH-1:0]  R0_data;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic              W0_clk;
  logic [WIDTH-1:0]  W0_data;
  logic [MASK_W-1:0] W0_mask;

  mem_1r1w_masked_client dut (
    .clock     (clk),
    .reset     (reset),
    .init_done (init_done),
    .bus       (bus),
    .R0_addr   (R0_addr),
    .R0_en     (R0_en),
    .R0_clk    (R0_clk),
    .R0_data   (R0_data),
    .W0_addr   (W0_addr),
    .W0_en     (W0_en),
    .W0_clk    (W0_clk),
    .W0_data   (W0_data),
    .W0_mask   (W0_mask)
  );

  // SRAM wrapper: masked write, registered read
  logic [WIDTH-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (W0_en && (W0_addr < DEPTH)) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (W0_mask[b]) sram[W0_addr][8*b +: 8] <= W0_data[8*b +: 8];
      end
    end
    if (R0_en && (R0_addr < DEPTH)) R0_data <= sram[R0_addr];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-level model: array contents, outstanding read responses, fill progress.
  typedef struct {
    logic        err;
    logic [63:0] data;
    int          vis;
  } exp_t;

  logic [63:0] ref_mem [DEPTH];
  exp_t        q[$];
  int          cyc = 0;
  int          init_cnt = 0;
  bit          prev_rst = 1'b0;
  bit          in_init, exp_ready, exp_rv, hs, ok_addr;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_r0_en", R0_en, 0);
      chk("rst_w0_en", W0_en, 0);
      if (prev_rst) begin
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_init_done", init_done, 0);
      end
      q.delete();
      init_cnt = 0;
    end else begin
      in_init   = init_cnt < DEPTH;
      exp_ready = !in_init && (q.size() < 2);
      exp_rv    = (q.size() > 0) && (q[0].vis <= cyc);
      hs        = bus.req_valid && exp_ready;
      ok_addr   = bus.req_addr < DEPTH;
      chk("req_ready", bus.req_ready, exp_ready);
      chk("init_done", init_done, !in_init);
      chk("resp_valid", bus.resp_valid, exp_rv);
      if (exp_rv && bus.resp_valid) begin
        chk("resp_err", bus.resp_err, q[0].err);
        chk("resp_data", bus.resp_data, q[0].data);
      end
      chk("w0_en", W0_en, in_init || (hs && bus.req_write && ok_addr));
      if (in_init) begin
        chk("fill_addr", W0_addr, init_cnt);
        chk("fill_mask", W0_mask, 8'hFF);
        chk("fill_data", W0_data, 0);
        ref_mem[init_cnt] = '0;
        init_cnt++;
      end else if (hs && bus.req_write && ok_addr) begin
        chk("w0_addr", W0_addr, bus.req_addr);
        chk("w0_data", W0_data, bus.req_data);
        chk("w0_mask", W0_mask, bus.req_mask);
        for (int b = 0; b < MASK_W; b++) begin
          if (bus.req_mask[b]) ref_mem[bus.req_addr][8*b +: 8] = bus.req_data[8*b +: 8];
        end
      end
      chk("r0_en", R0_en, hs && !bus.req_write && ok_addr);
      if (hs && !bus.req_write && ok_addr) chk("r0_addr", R0_addr, bus.req_addr);
      if (hs && !bus.req_write) begin
        q.push_back('{err: !ok_addr, data: ok_addr ? ref_mem[bus.req_addr] : 64'h0, vis: cyc + 1});
      end
      if (exp_rv && bus.resp_ready) void'(q.pop_front());
    end
    prev_rst = reset;
    cyc++;
  end

  task automatic do_req(input logic wr, input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_mask  = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) return;
      @(posedge clk); #1;
    end
    chk("req_timeout", 0, 1);
  endtask

  task automatic drop();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic [63:0] d, input logic e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        chk({name, "_data"}, bus.resp_data, d);
        chk({name, "_err"}, bus.resp_err, e);
        return;
      end
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  bit accepted;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_mask   = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // zero-fill with a read already waiting
    bus.req_valid = 1'b1;
    for (int i = 0; i <= 48; i++) begin
      @(negedge clk);
      if (i == 0)  chk("fill_first_addr", W0_addr, 0);
      if (i == 47) begin
        chk("init_done_c47", init_done, 0);
        chk("fill_last_addr", W0_addr, 47);
      end
      if (i == 48) begin
        chk("init_done_c48", init_done, 1);
        chk("ready_c48", bus.req_ready, 1);
      end
    end
    drop();
    wait_resp("rd0", 64'h0, 1'b0);

    // masked merge
    do_req(1'b1, 6'd5, 64'h1122334455667788, 8'hFF);
    do_req(1'b1, 6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_req(1'b0, 6'd5, 64'h0, 8'h0);
    drop();
    wait_resp("rd5", 64'h11223344AAAAAAAA, 1'b0);

    // backpressure: third read must stall
    do_req(1'b1, 6'd1, 64'h0101010101010101, 8'hFF);
    do_req(1'b1, 6'd2, 64'h0202020202020202, 8'hFF);
    drop();
    bus.resp_ready = 1'b0;
    do_req(1'b0, 6'd1, 64'h0, 8'h0);
    do_req(1'b0, 6'd2, 64'h0, 8'h0);
    @(posedge clk); #1;
    bus.req_addr = 6'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd3_blocked", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    wait_resp("bp_rd1", 64'h0101010101010101, 1'b0);
    wait_resp("bp_rd2", 64'h0202020202020202, 1'b0);

    // out-of-range read and write
    do_req(1'b0, 6'd48, 64'h0, 8'h0);
    chk("oob_r0_en", R0_en, 0);
    drop();
    wait_resp("oob_rd", 64'h0, 1'b1);
    do_req(1'b1, 6'd63, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    chk("oob_w0_en", W0_en, 0);
    drop();

    // write then read same entry on the next cycle
    do_req(1'b1, 6'd33, 64'hDEADBEEF00000001, 8'hFF);
    do_req(1'b0, 6'd33, 64'h0, 8'h0);
    drop();
    @(negedge clk);
    chk("wr_rd33_valid", bus.resp_valid, 1);
    chk("wr_rd33_data", bus.resp_data, 64'hDEADBEEF00000001);

    // reset with a response pending, then reset again mid-fill
    bus.resp_ready = 1'b0;
    do_req(1'b0, 6'd7, 64'h0, 8'h0);
    drop();
    @(negedge clk);
    chk("pending_before_rst", bus.resp_valid, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i == 0)  chk("flushed_resp_valid", bus.resp_valid, 0);
      if (i == 20) chk("fill_addr_20", W0_addr, 20);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i <= 48; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("refill_addr0", W0_addr, 0);
        chk("refill_resp_valid", bus.resp_valid, 0);
      end
      if (i == 47) chk("refill_done_c47", init_done, 0);
      if (i == 48) chk("refill_done_c48", init_done, 1);
    end

    // randomized traffic against the model
    accepted = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      if (!bus.req_valid || accepted) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = ($urandom_range(0, 9) == 0) ? 6'(48 + $urandom_range(0, 15))
                                                    : 6'($urandom_range(0, 15));
        bus.req_data  = {$urandom, $urandom};
        bus.req_mask  = 8'($urandom_range(0, 255));
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accepted = bus.req_valid && bus.req_ready;
    end
    drop();
    bus.resp_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
